button_bounce_gen: RTL and testbench

Synthesizable contact-bounce emulator: the transmit-side counterpart of the button debouncer. It converts a clean level command into a bouncing `noisy` waveform with a programmable number of glitches and (optionally pseudo-random) inter-toggle gaps. It drives the debouncer's `noisy` input in hardware-in-the-loop self-test and in FPGA demo builds where no physical switch exists.

---
 rtl/button_bounce_gen_pkg.sv | 9 +
 rtl/button_bounce_gen_if.sv | 10 +
 rtl/button_bounce_gen_lfsr.sv | 14 +
 rtl/button_bounce_gen.sv | 102 ++++++++++
 tb/tb_button_bounce_gen.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/button_bounce_gen_pkg.sv
// bounce_pkg: shared FSM state type, LFSR constants and a width helper for the bounce emulator.
package bounce_pkg;
  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/button_bounce_gen_if.sv
// button_bounce_gen_if: command/status bundle between a bounce emulator and its controller.
interface button_bounce_gen_if;
  logic en;
  logic level_in;
  logic noisy;
  logic busy;
  logic done;
  modport master (output en, level_in, input noisy, busy, done);
  modport slave (input en, level_in, output noisy, busy, done);
endinterface

// File: rtl/button_bounce_gen_lfsr.sv
// lfsr16: 16-bit Galois LFSR that advances only when stepped; a zero seed falls back to the default.
module lfsr16
  import bounce_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= (seed == '0) ? LFSR_SEED_DEFAULT : seed;
    else if (step) q <= q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
endmodule

// File: rtl/button_bounce_gen.sv
// button_bounce_gen: turns a clean level command into a bouncing contact waveform with programmable glitches and gaps.
module button_bounce_gen
  import bounce_pkg::*;
#(
  parameter int          N_BOUNCES   = 5,
  parameter int          GAP_MIN     = 125_000,
  parameter int          JITTER_MASK = 0,
  parameter int          HOLD_CYCLES = 5_000_000,
  parameter logic [15:0] SEED        = 16'hACE1
)(
  input logic               clk,
  input logic               reset_n,
  button_bounce_gen_if.slave bus
);
  localparam int GW = $clog2(GAP_MIN + JITTER_MASK + 1);
  localparam int CW = imax(GW, $clog2(HOLD_CYCLES + 1));
  localparam int TW = imax(1, $clog2(2 * N_BOUNCES + 1));
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TOG_LD = TW'(2 * N_BOUNCES - 1);
  state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx, w_gap;
  logic [TW-1:0] r_tcnt, w_tcnt_nx;
  logic r_noisy, w_noisy_nx, r_settled, w_settled_nx, r_done, w_done_nx, w_step;
  logic [15:0] w_lfsr;
  lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (w_step),
    .seed    (SEED),
    .q       (w_lfsr)
  );
  // Counters load gap-1 / hold-1 so the event fires exactly gap / hold edges after the load.
  assign w_gap = CW'(GAP_MIN) + CW'(w_lfsr & 16'(JITTER_MASK)) - CW'(1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_noisy   <= 1'b0;
      r_settled <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_tcnt    <= w_tcnt_nx;
      r_noisy   <= w_noisy_nx;
      r_settled <= w_settled_nx;
      r_done    <= w_done_nx;
    end
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_tcnt_nx    = r_tcnt;
    w_noisy_nx   = r_noisy;
    w_settled_nx = r_settled;
    w_done_nx    = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.en) begin
          w_noisy_nx   = bus.level_in;
          w_settled_nx = bus.level_in;
        end else if (bus.level_in != r_settled) begin
          w_noisy_nx   = bus.level_in;
          w_settled_nx = bus.level_in;
          if (N_BOUNCES == 0) begin
            w_state_nx = SETTLE;
            w_cnt_nx   = HOLD_LD;
          end else begin
            w_state_nx = BOUNCE;
            w_cnt_nx   = w_gap;
            w_tcnt_nx  = TOG_LD;
            w_step     = 1'b1;
          end
        end
      end
      BOUNCE: begin
        if (r_cnt == '0) begin
          w_noisy_nx = ~r_noisy;
          if (r_tcnt == '0) begin
            w_state_nx = SETTLE;
            w_cnt_nx   = HOLD_LD;
          end else begin
            w_tcnt_nx = r_tcnt - TW'(1);
            w_cnt_nx  = w_gap;
            w_step    = 1'b1;
          end
        end else w_cnt_nx = r_cnt - CW'(1);
      end
      SETTLE: begin
        if (r_cnt == '0) begin
          w_done_nx  = 1'b1;
          w_state_nx = IDLE;
        end else w_cnt_nx = r_cnt - CW'(1);
      end
      default: w_state_nx = IDLE;
    endcase
  end
  assign bus.noisy = r_noisy;
  assign bus.busy  = r_state != IDLE;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_button_bounce_gen.sv
// tb_button_bounce_gen: directed checks of bounce timing, retrigger, bypass, async reset and LFSR jitter.
module tb_button_bounce_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rst_j_n = 1'b1;
  logic lvl_j = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int rec = 0;
  int seed_diff = 0;
  bit tr0[$];
  bit tr1[$];
  bit seen[4];
  always #5 clk = ~clk;
  button_bounce_gen_if ifc_a ();
  button_bounce_gen_if ifc_j1 ();
  button_bounce_gen_if ifc_j0 ();
  button_bounce_gen_if ifc_jd ();
  assign ifc_j1.en = 1'b1;
  assign ifc_j0.en = 1'b1;
  assign ifc_jd.en = 1'b1;
  assign ifc_j1.level_in = lvl_j;
  assign ifc_j0.level_in = lvl_j;
  assign ifc_jd.level_in = lvl_j;
  button_bounce_gen #(.N_BOUNCES(2), .GAP_MIN(4), .JITTER_MASK(0), .HOLD_CYCLES(10)) u_dut (
    .clk(clk), .reset_n(rst_n), .bus(ifc_a));
  button_bounce_gen #(.N_BOUNCES(2), .GAP_MIN(4), .JITTER_MASK(3), .HOLD_CYCLES(10), .SEED(16'h0001)) u_j1 (
    .clk(clk), .reset_n(rst_j_n), .bus(ifc_j1));
  button_bounce_gen #(.N_BOUNCES(2), .GAP_MIN(4), .JITTER_MASK(3), .HOLD_CYCLES(10), .SEED(16'h0000)) u_j0 (
    .clk(clk), .reset_n(rst_j_n), .bus(ifc_j0));
  button_bounce_gen #(.N_BOUNCES(2), .GAP_MIN(4), .JITTER_MASK(3), .HOLD_CYCLES(10), .SEED(16'hACE1)) u_jd (
    .clk(clk), .reset_n(rst_j_n), .bus(ifc_jd));
  always @(negedge clk)
    if (rec != 0) begin
      if (ifc_j0.noisy !== ifc_jd.noisy) seed_diff++;
      if (rec == 1) tr0.push_back(ifc_j1.noisy);
      else tr1.push_back(ifc_j1.noisy);
    end
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic bit exp_noisy(input int n, input bit lvl);
    return n < 16 ? lvl ^ bit'((n / 4) % 2) : lvl;
  endfunction
  // n counts edges since the sequence's first edge; gaps of 4, hold of 10.
  task automatic follow(input bit lvl, input int nmax, input int flip_at);
    for (int n = 0; n <= nmax; n++) begin
      tick();
      chk("noisy", ifc_a.noisy, exp_noisy(n, lvl));
      chk("busy", ifc_a.busy, int'(n <= 25));
      chk("done", ifc_a.done, int'(n == 26));
      if (n == flip_at) ifc_a.level_in = ~ifc_a.level_in;
    end
  endtask
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction
  task automatic jit_run(input int pass);
    logic [15:0] m;
    bit lv;
    bit prev;
    int g;
    int eg;
    m = 16'h0001;
    lv = 1'b0;
    lvl_j = 1'b0;
    rst_j_n = 1'b0;
    tick();
    rst_j_n = 1'b1;
    rec = pass;
    tick();
    for (int s = 0; s < 20; s++) begin
      lv = ~lv;
      lvl_j = lv;
      tick();
      chk("j_first", ifc_j1.noisy, lv);
      for (int j = 1; j <= 4; j++) begin
        g = 0;
        prev = ifc_j1.noisy;
        do begin
          tick();
          g++;
        end while (ifc_j1.noisy == prev && g < 20);
        eg = 4 + int'(m & 16'h3);
        m = lfsr_next(m);
        chk("j_gap", g, eg);
        chk("j_gap_range", int'(g >= 4 && g <= 7), 1);
        if (g >= 4 && g <= 7) seen[g-4] = 1'b1;
      end
      g = 0;
      while (!ifc_j1.done && g < 40) begin
        tick();
        g++;
      end
      chk("j_done", ifc_j1.done, 1);
    end
    rec = 0;
  endtask
  initial begin
    int distinct;
    int tdiff;
    ifc_a.en = 1'b1;
    ifc_a.level_in = 1'b0;
    #1 rst_n = 1'b0;
    rst_j_n = 1'b0;
    #1;
    chk("rst_noisy", ifc_a.noisy, 0);
    chk("rst_busy", ifc_a.busy, 0);
    chk("rst_done", ifc_a.done, 0);
    #7 rst_n = 1'b1;
    rst_j_n = 1'b1;
    tick();
    tick();
    chk("idle_noisy", ifc_a.noisy, 0);
    ifc_a.level_in = 1'b1;
    follow(1'b1, 26, 5);
    follow(1'b0, 27, -1);
    ifc_a.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifc_a.level_in = (i % 2 == 0);
      #0;
      chk("byp_hold", ifc_a.noisy, int'(i % 2 != 0));
      tick();
      chk("byp_noisy", ifc_a.noisy, int'(i % 2 == 0));
      chk("byp_busy", ifc_a.busy, 0);
      chk("byp_done", ifc_a.done, 0);
    end
    ifc_a.en = 1'b1;
    ifc_a.level_in = 1'b1;
    follow(1'b1, 9, -1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_noisy", ifc_a.noisy, 0);
    chk("mid_rst_busy", ifc_a.busy, 0);
    chk("mid_rst_done", ifc_a.done, 0);
    repeat (11) tick();
    chk("rst_held_noisy", ifc_a.noisy, 0);
    rst_n = 1'b1;
    follow(1'b1, 27, -1);
    jit_run(1);
    jit_run(2);
    distinct = 0;
    for (int i = 0; i < 4; i++) distinct += int'(seen[i]);
    chk("j_distinct_ge2", int'(distinct >= 2), 1);
    chk("seed0_eq_ace1", seed_diff, 0);
    chk("repeat_len", tr1.size(), tr0.size());
    tdiff = 0;
    for (int i = 0; i < tr0.size() && i < tr1.size(); i++) if (tr0[i] != tr1[i]) tdiff++;
    chk("repeat_trace", tdiff, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
